// File: rtl/connect4.sv
// Connect-four game engine driving a 32x32 RGB LED panel.
// Holds the 6x7 board, cursor and turn state, detects wins through the
// WIN submodule and continuously scans the board onto the panel.

module connect4_win (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0][6:0][1:0] board,
  output logic                 ver,
  output logic                 hor,
  output logic                 Rdiag,
  output logic                 Ldiag,
  output logic                 winflag,
  output logic [1:0]           winner
);

  logic [20:0] verHit, verP1;
  logic [23:0] horHit, horP1;
  logic [11:0] rdHit, rdP1;
  logic [11:0] ldHit, ldP1;
  logic        anyLine, anyP1;

  function automatic logic four(input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] c, input logic [1:0] d);
    return (a != 2'd0) && (a == b) && (a == c) && (a == d);
  endfunction

  for (genvar r = 0; r < 3; r++) begin : g_ver_r
    for (genvar c = 0; c < 7; c++) begin : g_ver_c
      assign verHit[r*7+c] = four(board[r][c], board[r+1][c], board[r+2][c], board[r+3][c]);
      assign verP1[r*7+c]  = verHit[r*7+c] && (board[r][c] == 2'd1);
    end
  end

  for (genvar r = 0; r < 6; r++) begin : g_hor_r
    for (genvar c = 0; c < 4; c++) begin : g_hor_c
      assign horHit[r*4+c] = four(board[r][c], board[r][c+1], board[r][c+2], board[r][c+3]);
      assign horP1[r*4+c]  = horHit[r*4+c] && (board[r][c] == 2'd1);
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_diag_r
    for (genvar c = 0; c < 4; c++) begin : g_diag_c
      assign rdHit[r*4+c] = four(board[r][c], board[r+1][c+1], board[r+2][c+2], board[r+3][c+3]);
      assign rdP1[r*4+c]  = rdHit[r*4+c] && (board[r][c] == 2'd1);
      assign ldHit[r*4+c] = four(board[r][c+3], board[r+1][c+2], board[r+2][c+1], board[r+3][c]);
      assign ldP1[r*4+c]  = ldHit[r*4+c] && (board[r][c+3] == 2'd1);
    end
  end

  assign ver     = |verHit;
  assign hor     = |horHit;
  assign Rdiag   = |rdHit;
  assign Ldiag   = |ldHit;
  assign anyLine = ver | hor | Rdiag | Ldiag;
  assign anyP1   = |{verP1, horP1, rdP1, ldP1};

  // Latch the first win and its owner; both hold until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winflag <= 1'b0;
      winner  <= 2'd0;
    end else if (!winflag && anyLine) begin
      winflag <= 1'b1;
      winner  <= anyP1 ? 2'd1 : 2'd2;
    end
  end

endmodule

module connect4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       L,
  input  logic       E,
  input  logic       R,
  output logic       clko,
  output logic [3:0] ABCD,
  output logic       R1,
  output logic       G1,
  output logic       B1,
  output logic       R2,
  output logic       G2,
  output logic       B2,
  output logic       La,
  output logic       En
);

  typedef enum logic [1:0] {SHIFT, BLANK, LATCH} scan_t;

  logic [5:0][6:0][1:0] board;
  logic [2:0]           cursor;
  logic [1:0]           player;
  logic                 lReg, eReg, rReg;
  logic                 lPress, ePress, rPress;
  logic                 ver, hor, Rdiag, Ldiag, winflag, frozen;
  logic [1:0]           winner;
  logic [5:0]           emptyRows;
  logic [2:0]           dropRow;
  logic                 dropOk;

  scan_t                state;
  logic [4:0]           slot;
  logic                 phase;
  logic                 rowAdvance;
  logic [3:0]           rowNow;
  logic [2:0]           upperRgb, lowerRgb;

  connect4_win WIN (
    .clk     (clk),
    .rst     (rst),
    .board   (board),
    .ver     (ver),
    .hor     (hor),
    .Rdiag   (Rdiag),
    .Ldiag   (Ldiag),
    .winflag (winflag),
    .winner  (winner)
  );

  // A press is a high sample followed by a low one; a completed line also
  // freezes play in the cycle before winflag registers.
  assign lPress = lReg & ~L;
  assign ePress = eReg & ~E;
  assign rPress = rReg & ~R;
  assign frozen = winflag | ver | hor | Rdiag | Ldiag;

  for (genvar r = 0; r < 6; r++) begin : g_empty
    assign emptyRows[r] = (board[r][cursor] == 2'd0);
  end

  // Pick the lowest free cell (highest row index) of the cursor column.
  always_comb begin
    dropOk  = |emptyRows;
    dropRow = 3'd0;
    if      (emptyRows[5]) dropRow = 3'd5;
    else if (emptyRows[4]) dropRow = 3'd4;
    else if (emptyRows[3]) dropRow = 3'd3;
    else if (emptyRows[2]) dropRow = 3'd2;
    else if (emptyRows[1]) dropRow = 3'd1;
    else                   dropRow = 3'd0;
  end

  // Game state: button history, cursor movement, drops and turn order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board  <= '0;
      cursor <= 3'd6;
      player <= 2'd1;
      lReg   <= 1'b1;
      eReg   <= 1'b1;
      rReg   <= 1'b1;
    end else begin
      lReg <= L;
      eReg <= E;
      rReg <= R;
      if (!frozen) begin
        if (ePress) begin
          if (dropOk) begin
            board[dropRow][cursor] <= player;
            player                 <= (player == 2'd1) ? 2'd2 : 2'd1;
            cursor                 <= 3'd6;
          end
        end else if (lPress && !rPress) begin
          cursor <= (cursor == 3'd0) ? 3'd6 : cursor - 3'd1;
        end else if (rPress && !lPress) begin
          cursor <= (cursor == 3'd6) ? 3'd0 : cursor + 3'd1;
        end
      end
    end
  end

  function automatic logic [2:0] colourOf(input logic [1:0] p);
    case (p)
      2'd1:    return 3'b100;
      2'd2:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] pixel(input logic [4:0] x, input logic [4:0] y);
    logic [2:0] band;
    logic [2:0] col;
    logic [2:0] rgb;
    band = y[4:2];
    col  = x[4:2];
    rgb  = 3'b000;
    if (col == 3'd7 || x[1:0] == 2'b11 || y[1:0] == 2'b11) begin
      rgb = 3'b000;
    end else if (band == 3'd0) begin
      if (winflag)              rgb = colourOf(winner);
      else if (col == cursor)   rgb = colourOf(player);
    end else if (band != 3'd7) begin
      rgb = colourOf(board[band - 3'd1][col]);
    end
    return rgb;
  endfunction

  // The row being shifted is the next one when an address advance is pending.
  assign rowNow = rowAdvance ? ABCD + 4'd1 : ABCD;

  // Colour of the current slot for both panel halves.
  always_comb begin
    upperRgb = pixel(slot, {1'b0, rowNow});
    lowerRgb = pixel(slot, {1'b1, rowNow});
  end

  // Panel scan: 32 two-cycle slots, a blank cycle, a latch cycle, next row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SHIFT;
      slot       <= 5'd0;
      phase      <= 1'b0;
      rowAdvance <= 1'b0;
      ABCD       <= 4'd0;
      clko       <= 1'b0;
      La         <= 1'b0;
      En         <= 1'b1;
      {R1, G1, B1} <= 3'b000;
      {R2, G2, B2} <= 3'b000;
    end else begin
      case (state)
        SHIFT: begin
          if (!phase) begin
            clko         <= 1'b0;
            La           <= 1'b0;
            En           <= 1'b0;
            {R1, G1, B1} <= upperRgb;
            {R2, G2, B2} <= lowerRgb;
            if (rowAdvance) begin
              ABCD       <= ABCD + 4'd1;
              rowAdvance <= 1'b0;
            end
            phase <= 1'b1;
          end else begin
            clko  <= 1'b1;
            phase <= 1'b0;
            if (slot == 5'd31) begin
              slot  <= 5'd0;
              state <= BLANK;
            end else begin
              slot <= slot + 5'd1;
            end
          end
        end
        BLANK: begin
          clko         <= 1'b0;
          En           <= 1'b1;
          {R1, G1, B1} <= 3'b000;
          {R2, G2, B2} <= 3'b000;
          state        <= LATCH;
        end
        LATCH: begin
          La         <= 1'b1;
          rowAdvance <= 1'b1;
          state      <= SHIFT;
        end
        default: state <= SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4.sv
// Directed self-checking bench for connect4: reset, scan timing, cursor
// handling, drops, full columns and the four kinds of winning line.

module tb_connect4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       L = 1'b1;
  logic       E = 1'b1;
  logic       R = 1'b1;
  logic       clko, La, En;
  logic [3:0] ABCD;
  logic       R1, G1, B1, R2, G2, B2;

  int assertCount = 0;
  int failCount   = 0;
  int rises0 = 0, rises1 = 0, la0 = 0, la1 = 0;
  logic prevClko = 1'b0;
  logic laEn0 = 1'b0, laEn1 = 1'b0;

  localparam int BTN_L = 0;
  localparam int BTN_E = 1;
  localparam int BTN_R = 2;

  connect4 dut (
    .clk  (clk),
    .rst  (rst),
    .L    (L),
    .E    (E),
    .R    (R),
    .clko (clko),
    .ABCD (ABCD),
    .R1   (R1),
    .G1   (G1),
    .B1   (B1),
    .R2   (R2),
    .G2   (G2),
    .B2   (B2),
    .La   (La),
    .En   (En)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int btn, input int n);
    for (int i = 0; i < n; i++) begin
      case (btn)
        BTN_L:   L = 1'b0;
        BTN_E:   E = 1'b0;
        default: R = 1'b0;
      endcase
      tick(2);
      L = 1'b1;
      E = 1'b1;
      R = 1'b1;
      tick(2);
    end
  endtask

  task automatic drop(input int col);
    applyStimulus(BTN_R, (col + 1) % 7);
    applyStimulus(BTN_E, 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic waitAbcd(input logic [3:0] target);
    int n;
    n = 0;
    while (ABCD == target && n < 1200) begin tick(1); n++; end
    n = 0;
    while (ABCD != target && n < 1200) begin tick(1); n++; end
    checkOutput("ABCD reached", ABCD, target);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] connect4 directed test start");
    tick(3);
    checkOutput("reset cursor", dut.cursor, 6);
    checkOutput("reset player", dut.player, 1);
    checkOutput("reset winflag", dut.WIN.winflag, 0);
    checkOutput("reset board empty", 32'(dut.board !== '0), 0);
    checkOutput("reset En", En, 1);
    checkOutput("reset clko", clko, 0);
    checkOutput("reset La", La, 0);
    checkOutput("reset ABCD", ABCD, 0);

    // Scan timing over two rows after release.
    rst = 1'b0;
    for (int i = 1; i <= 133; i++) begin
      @(negedge clk);
      if (i == 1)  checkOutput("pixel x0 black", {R1, G1, B1}, 3'b000);
      if (i == 49) checkOutput("cursor pixel red", {R1, G1, B1}, 3'b100);
      if (i == 55) checkOutput("gap pixel black", {R1, G1, B1}, 3'b000);
      if (i == 65) checkOutput("blank En", {En, La}, 2'b10);
      if (i == 66) checkOutput("latch cycle", {En, La, ABCD}, {2'b11, 4'd0});
      if (i == 67) checkOutput("row1 start", {En, La, ABCD}, {2'b00, 4'd1});
      if (i == 133) checkOutput("row2 start", ABCD, 2);
      if (i <= 66) begin
        if (clko && !prevClko) rises0++;
        if (La) begin la0++; laEn0 = En; end
      end else if (i <= 132) begin
        if (clko && !prevClko) rises1++;
        if (La) begin la1++; laEn1 = En; end
      end
      prevClko = clko;
    end
    checkOutput("row0 clko rises", rises0, 32);
    checkOutput("row0 La count", la0, 1);
    checkOutput("row0 En during La", laEn0, 1);
    checkOutput("row1 clko rises", rises1, 32);
    checkOutput("row1 La count", la1, 1);
    checkOutput("row1 En during La", laEn1, 1);

    // First drop lands at the bottom of column 0.
    doReset();
    applyStimulus(BTN_R, 1);
    checkOutput("cursor after R", dut.cursor, 0);
    applyStimulus(BTN_E, 1);
    checkOutput("drop board[5][0]", dut.board[5][0], 1);
    checkOutput("drop board[4][0]", dut.board[4][0], 0);
    checkOutput("drop player", dut.player, 2);
    checkOutput("drop cursor home", dut.cursor, 6);
    waitAbcd(4'd8);
    checkOutput("panel lower red piece", {R2, G2, B2}, 3'b100);
    checkOutput("panel upper empty", {R1, G1, B1}, 3'b000);

    // Held L moves once; simultaneous L/R ignored; E beats R.
    L = 1'b0;
    tick(10);
    L = 1'b1;
    tick(2);
    checkOutput("held L once", dut.cursor, 5);
    L = 1'b0; R = 1'b0;
    tick(2);
    L = 1'b1; R = 1'b1;
    tick(2);
    checkOutput("L+R ignored", dut.cursor, 5);
    E = 1'b0; R = 1'b0;
    tick(2);
    E = 1'b1; R = 1'b1;
    tick(2);
    checkOutput("E+R drop", dut.board[5][5], 2);
    checkOutput("E+R cursor home", dut.cursor, 6);
    checkOutput("E+R player", dut.player, 1);

    // Alternating columns until player 1 completes column 0 vertically.
    doReset();
    for (int round = 0; round < 3; round++)
      for (int c = 0; c < 4; c++) drop(c);
    applyStimulus(BTN_R, 1);
    checkOutput("pre-win winflag", dut.WIN.winflag, 0);
    E = 1'b0;
    tick(1);
    checkOutput("13th drop piece", dut.board[2][0], 1);
    checkOutput("13th drop ver", dut.WIN.ver, 1);
    checkOutput("winflag not yet", dut.WIN.winflag, 0);
    tick(1);
    checkOutput("winflag next clock", dut.WIN.winflag, 1);
    checkOutput("winner p1 ver", dut.WIN.winner, 1);
    E = 1'b1;
    tick(2);
    drop(1);
    drop(2);
    checkOutput("frozen cursor", dut.cursor, 6);
    checkOutput("frozen board[2][1]", dut.board[2][1], 0);
    checkOutput("frozen board[5][6]", dut.board[5][6], 0);
    checkOutput("frozen player", dut.player, 2);
    waitAbcd(4'd0);
    checkOutput("band shows winner", {R1, G1, B1}, 3'b100);

    // Seven drops into one column; the last is refused.
    doReset();
    for (int k = 0; k < 6; k++) drop(0);
    checkOutput("full col top", dut.board[0][0], 2);
    checkOutput("full col player", dut.player, 1);
    drop(0);
    checkOutput("7th drop player", dut.player, 1);
    checkOutput("7th drop cursor", dut.cursor, 0);
    checkOutput("7th drop bottom", dut.board[5][0], 1);
    checkOutput("7th drop top", dut.board[0][0], 2);

    // Horizontal line along the bottom row.
    doReset();
    drop(0); drop(0); drop(1); drop(1); drop(2); drop(2);
    checkOutput("hor before", dut.WIN.hor, 0);
    drop(3);
    checkOutput("hor after", dut.WIN.hor, 1);
    checkOutput("hor ver clear", dut.WIN.ver, 0);
    checkOutput("hor winflag", dut.WIN.winflag, 1);
    checkOutput("hor winner", dut.WIN.winner, 1);

    // Down-left diagonal staircase (5,0)..(2,3).
    doReset();
    drop(0); drop(1); drop(1); drop(2); drop(2);
    drop(3); drop(2); drop(3); drop(3); drop(6);
    checkOutput("Ldiag before", dut.WIN.Ldiag, 0);
    checkOutput("Ldiag winflag before", dut.WIN.winflag, 0);
    drop(3);
    checkOutput("Ldiag after", dut.WIN.Ldiag, 1);
    checkOutput("Ldiag Rdiag clear", dut.WIN.Rdiag, 0);
    checkOutput("Ldiag winflag", dut.WIN.winflag, 1);
    checkOutput("Ldiag winner", dut.WIN.winner, 1);

    // Down-right diagonal staircase (2,3)..(5,6).
    doReset();
    drop(6); drop(5); drop(5); drop(4); drop(4);
    drop(3); drop(4); drop(3); drop(3); drop(0);
    checkOutput("Rdiag before", dut.WIN.Rdiag, 0);
    drop(3);
    checkOutput("Rdiag after", dut.WIN.Rdiag, 1);
    checkOutput("Rdiag Ldiag clear", dut.WIN.Ldiag, 0);
    checkOutput("Rdiag winflag", dut.WIN.winflag, 1);

    // Asynchronous reset in the middle of a game.
    doReset();
    drop(2);
    checkOutput("midgame piece", dut.board[5][2], 1);
    tick(37);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async board clear", 32'(dut.board !== '0), 0);
    checkOutput("async cursor", dut.cursor, 6);
    checkOutput("async player", dut.player, 1);
    checkOutput("async panel", {En, La, clko, ABCD}, {3'b100, 4'd0});
    tick(1);
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
